// File: rtl/dcache_uncache_bridge_if.sv
// dcache_uncache_bridge_if: pipeline request/response and memory-side bus of the uncached bridge.
// Ports: req_* (pipeline request + req_ready), rd_data/rd_valid (read return), wbuf_empty,
//        mem_* (memory request, write data, byte enables, size, read line, addrOK/dataOK).
// Modports: slave = the bridge, master = the pipeline/memory environment driving it.
interface dcache_uncache_bridge_if #(
    parameter int OFFSET_W = 2
);
    logic                           req_valid;
    logic                           req_ready;
    logic                           req_type;
    logic [31:0]                    req_addr;
    logic [31:0]                    req_wdata;
    logic [3:0]                     req_wstrb;
    logic [31:0]                    rd_data;
    logic                           rd_valid;
    logic                           wbuf_empty;
    logic [31:0]                    mem_addr;
    logic [31:0]                    mem_wdata;
    logic [32*(1<<OFFSET_W)-1:0]    mem_rline;
    logic                           mem_req;
    logic                           mem_wr;
    logic [1:0]                     mem_size;
    logic [3:0]                     mem_wstrb;
    logic                           mem_addrOK;
    logic                           mem_dataOK;
    modport slave (
        input  req_valid, req_type, req_addr, req_wdata, req_wstrb, mem_rline, mem_addrOK, mem_dataOK,
        output req_ready, rd_data, rd_valid, wbuf_empty, mem_addr, mem_wdata, mem_req, mem_wr, mem_size, mem_wstrb
    );
    modport master (
        output req_valid, req_type, req_addr, req_wdata, req_wstrb, mem_rline, mem_addrOK, mem_dataOK,
        input  req_ready, rd_data, rd_valid, wbuf_empty, mem_addr, mem_wdata, mem_req, mem_wr, mem_size, mem_wstrb
    );
endinterface

// File: rtl/dcache_uncache_bridge.sv
// dcache_uncache_bridge: uncached load/store bridge with a posted-write FIFO and a single outstanding read.
// Ports: clk, rstn (async, active-low), bus (dcache_uncache_bridge_if.slave): pipeline requests in,
//        read word/pulse out, memory request/size/strobes out, memory line and addrOK/dataOK in.
module dcache_uncache_bridge #(
    parameter int OFFSET_W   = 2,
    parameter int WBUF_DEPTH = 4
) (
    input logic                     clk,
    input logic                     rstn,
    dcache_uncache_bridge_if.slave  bus
);
    localparam int PW = $clog2(WBUF_DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(WBUF_DEPTH);

    typedef enum logic [1:0] {IDLE, WREQ, RREQ, RWAIT} state_t;

    state_t                             state;
    logic [31:0]                        wb_addr [WBUF_DEPTH];
    logic [31:0]                        wb_data [WBUF_DEPTH];
    logic [3:0]                         wb_strb [WBUF_DEPTH];
    logic [PW-1:0]                      rptr, wptr;
    logic [PW:0]                        count, count_nx;
    logic [31:0]                        raddr, rd_data;
    logic                               rd_valid;
    logic [(1<<OFFSET_W)-1:0][31:0]     line;
    logic [3:0]                         hs;
    logic                               accept, push, pop;

    assign line     = bus.mem_rline;
    assign hs       = wb_strb[rptr];
    // reads wait for an empty buffer in IDLE so they never overtake posted writes
    assign bus.req_ready = bus.req_type ? (count < FULL && state != RREQ && state != RWAIT)
                                        : (state == IDLE && count == '0);
    assign accept   = bus.req_valid && bus.req_ready;
    assign push     = accept && bus.req_type && bus.req_wstrb != 4'b0000;
    assign pop      = state == WREQ && bus.mem_addrOK;
    assign count_nx = count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};

    assign bus.mem_req    = state == WREQ || state == RREQ;
    assign bus.mem_wr     = state == WREQ;
    assign bus.mem_addr   = state == RREQ ? raddr : wb_addr[rptr];
    assign bus.mem_wdata  = wb_data[rptr];
    assign bus.mem_wstrb  = state == WREQ ? hs : 4'b0000;
    // a single set bit is a byte, an aligned half pair is a halfword, anything else a word
    assign bus.mem_size   = state == WREQ ? (((hs & (hs - 4'd1)) == 4'd0) ? 2'd0 :
                                             (hs == 4'b0011 || hs == 4'b1100) ? 2'd1 : 2'd2) :
                            state == RREQ ? 2'd2 : 2'd0;
    assign bus.wbuf_empty = count == '0 && state != WREQ;
    assign bus.rd_data    = rd_data;
    assign bus.rd_valid   = rd_valid;

    always_ff @(posedge clk) begin
        if (push) begin
            wb_addr[wptr] <= bus.req_addr;
            wb_data[wptr] <= bus.req_wdata;
            wb_strb[wptr] <= bus.req_wstrb;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            rptr     <= '0;
            wptr     <= '0;
            count    <= '0;
            raddr    <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            count    <= count_nx;
            if (push) wptr <= wptr + PW'(1);
            if (pop) rptr <= rptr + PW'(1);
            case (state)
                IDLE:
                    if (accept && !bus.req_type) begin
                        raddr <= bus.req_addr;
                        state <= RREQ;
                    end else if (count != '0) begin
                        state <= WREQ;
                    end
                WREQ:  if (pop && count_nx == '0) state <= IDLE;
                RREQ:  if (bus.mem_addrOK) state <= RWAIT;
                RWAIT:
                    if (bus.mem_dataOK) begin
                        rd_data  <= line[raddr[OFFSET_W+1:2]];
                        rd_valid <= 1'b1;
                        state    <= IDLE;
                    end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_uncache_bridge.sv
// tb_dcache_uncache_bridge: directed and randomized checks of the uncached bridge against a memory/order model.
module tb_dcache_uncache_bridge;
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  size;
    } w_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;
    w_t          exp_wq[$];
    w_t          iss_q[$];
    logic        auto_mem = 1'b0;
    logic        m_aok = 1'b0, m_dok = 1'b0, a_aok = 1'b0, a_dok = 1'b0;
    logic        pend = 1'b0;
    int          dly = 0;
    logic [31:0] lat_addr = '0;
    logic        ovr = 1'b0;
    logic [31:0] ovr_w [4];
    logic [127:0] rl;

    dcache_uncache_bridge_if #(.OFFSET_W(2)) bus ();

    dcache_uncache_bridge #(.OFFSET_W(2), .WBUF_DEPTH(4)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk_word(input logic [31:0] a, input int i);
        return {a[31:4], 4'h0} ^ (32'(i) * 32'h0101_0101) ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [1:0] exp_size(input logic [3:0] s);
        return ($countones(s) == 1) ? 2'd0 : (s == 4'b0011 || s == 4'b1100) ? 2'd1 : 2'd2;
    endfunction

    always_comb begin
        rl = '0;
        for (int i = 0; i < 4; i++) rl[i*32 +: 32] = ovr ? ovr_w[i] : mk_word(lat_addr, i);
    end

    assign bus.mem_rline  = rl;
    assign bus.mem_addrOK = auto_mem ? a_aok : m_aok;
    assign bus.mem_dataOK = auto_mem ? a_dok : m_dok;

    // memory model: latches read line address, logs issued writes, and answers randomly in auto mode
    always @(posedge clk) begin
        if (bus.mem_req && !bus.mem_wr && bus.mem_addrOK) begin
            lat_addr = bus.mem_addr;
            if (auto_mem) begin
                pend = 1'b1;
                dly = $urandom_range(0, 3);
            end
        end else if (a_dok) pend = 1'b0;
        else if (pend && dly != 0) dly--;
        if (rstn && bus.mem_req && bus.mem_wr && bus.mem_addrOK)
            iss_q.push_back('{bus.mem_addr, bus.mem_wdata, bus.mem_wstrb, bus.mem_size});
        #1;
        a_aok = auto_mem && bus.mem_req && $urandom_range(0, 2) != 0;
        a_dok = auto_mem && pend && dly == 0;
    end

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_acc(input int budget, output bit acc);
        int w = 0;
        acc = 1'b0;
        forever begin
            #1;
            if (bus.req_ready) begin
                acc = 1'b1;
                break;
            end
            if (w == budget) break;
            @(negedge clk);
            w++;
        end
        if (acc) begin
            @(posedge clk);
            @(negedge clk);
            bus.req_valid = 1'b0;
        end
    endtask

    task automatic send(input bit t, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input int budget, output bit acc);
        bus.req_valid = 1'b1;
        bus.req_type  = t;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_wstrb = s;
        wait_acc(budget, acc);
        if (acc && t && s != 4'b0000) exp_wq.push_back('{a, d, s, exp_size(s)});
    endtask

    task automatic wait_memreq(input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            #1;
            if (bus.mem_req) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_empty(input string tag, input int budget);
        bit ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (bus.wbuf_empty) begin
                ok = 1'b1;
                break;
            end
        end
        chk(tag, 72'(ok), 72'd1);
    endtask

    task automatic check_writes(input string tag);
        w_t e, o;
        chk({tag, "_n"}, 72'(iss_q.size()), 72'(exp_wq.size()));
        while (exp_wq.size() > 0 && iss_q.size() > 0) begin
            e = exp_wq.pop_front();
            o = iss_q.pop_front();
            chk({tag, "_w"}, 72'(o), 72'(e));
        end
        exp_wq.delete();
        iss_q.delete();
    endtask

    task automatic pulse_aok();
        m_aok = 1'b1;
        @(negedge clk);
        m_aok = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        bit          acc, ok, seen;
        logic [31:0] a, d;
        logic [3:0]  s;
        logic [31:0] wd [6];
        logic [3:0]  strbs [3];
        bus.req_valid = 1'b0;
        bus.req_type  = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_wstrb = '0;
        ovr_w[0] = 32'h1111_1111;
        ovr_w[1] = 32'hDEAD_BEEF;
        ovr_w[2] = 32'h2222_2222;
        ovr_w[3] = 32'h3333_3333;
        #2;
        chk("rst_ready", 72'(bus.req_ready), 72'd1);
        chk("rst_empty", 72'(bus.wbuf_empty), 72'd1);
        chk("rst_rdv", 72'(bus.rd_valid), 72'd0);
        chk("rst_rdata", 72'(bus.rd_data), 72'd0);
        chk("rst_memreq", 72'({bus.mem_req, bus.mem_wr, bus.mem_wstrb, bus.mem_size}), 72'd0);
        @(negedge clk);
        rstn = 1'b1;
        ovr = 1'b1;
        send(1'b0, 32'h104, 32'h0, 4'h0, 3, acc);
        chk("rd_acc", 72'(acc), 72'd1);
        #1;
        chk("rd_rreq", 72'({bus.mem_req, bus.mem_wr, bus.mem_size, bus.mem_wstrb}), 72'({1'b1, 1'b0, 2'd2, 4'h0}));
        chk("rd_addr", 72'(bus.mem_addr), 72'h104);
        pulse_aok();
        #1;
        chk("rd_rwait_noreq", 72'(bus.mem_req), 72'd0);
        m_dok = 1'b1;
        @(negedge clk);
        m_dok = 1'b0;
        chk("rd_valid", 72'(bus.rd_valid), 72'd1);
        chk("rd_data", 72'(bus.rd_data), 72'hDEADBEEF);
        @(negedge clk);
        chk("rd_pulse", 72'(bus.rd_valid), 72'd0);
        chk("rd_hold", 72'(bus.rd_data), 72'hDEADBEEF);
        ovr = 1'b0;
        m_dok = 1'b1;
        @(negedge clk);
        m_dok = 1'b0;
        @(negedge clk);
        chk("dok_idle_ignored", 72'({bus.rd_valid, bus.rd_data}), 72'({1'b0, 32'hDEADBEEF}));
        for (int i = 0; i < 4; i++) begin
            wd[i] = $urandom;
            send(1'b1, 32'h1000 + 32'(4 * i), wd[i], 4'hF, 0, acc);
            chk("burst_acc", 72'(acc), 72'd1);
        end
        chk("burst_head", 72'({bus.mem_req, bus.mem_wr, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb}),
            72'({1'b1, 1'b1, 32'h1000, wd[0], 4'hF}));
        chk("burst_notempty", 72'(bus.wbuf_empty), 72'd0);
        wd[4] = $urandom;
        send(1'b1, 32'h1010, wd[4], 4'hF, 4, acc);
        chk("burst_stall", 72'(acc), 72'd0);
        chk("burst_head_stable", 72'(bus.mem_addr), 72'h1000);
        m_aok = 1'b1;
        wait_acc(10, acc);
        chk("burst_5th_acc", 72'(acc), 72'd1);
        if (acc) exp_wq.push_back('{32'h1010, wd[4], 4'hF, 2'd2});
        wait_empty("burst_drain", 20);
        m_aok = 1'b0;
        check_writes("burst");
        strbs[0] = 4'b0100;
        strbs[1] = 4'b1100;
        strbs[2] = 4'b0111;
        for (int i = 0; i < 3; i++) begin
            send(1'b1, 32'h300, 32'hA5A5_5A5A, strbs[i], 3, acc);
            wait_memreq(4, ok);
            chk("size_req", 72'(ok), 72'd1);
            chk("size_val", 72'({bus.mem_size, bus.mem_wstrb}), 72'({2'(i), strbs[i]}));
            pulse_aok();
        end
        send(1'b1, 32'h304, 32'h1234_5678, 4'b0000, 3, acc);
        chk("zero_acc", 72'(acc), 72'd1);
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            seen |= bus.mem_req;
        end
        chk("zero_noreq", 72'({seen, bus.wbuf_empty}), 72'({1'b0, 1'b1}));
        check_writes("size");
        send(1'b1, 32'h200, 32'hCAFE_0200, 4'hF, 3, acc);
        bus.req_valid = 1'b1;
        bus.req_type  = 1'b0;
        bus.req_addr  = 32'h200;
        wait_acc(6, acc);
        chk("ord_rd_blocked", 72'(acc), 72'd0);
        chk("ord_wr_pending", 72'({bus.mem_req, bus.mem_wr, bus.mem_addr}), 72'({1'b1, 1'b1, 32'h200}));
        @(negedge clk);
        pulse_aok();
        #1;
        chk("ord_after_aok", 72'({bus.mem_req, bus.req_ready}), 72'({1'b0, 1'b1}));
        wait_acc(2, acc);
        chk("ord_rd_acc", 72'(acc), 72'd1);
        #1;
        chk("ord_rd_req", 72'({bus.mem_req, bus.mem_wr, bus.mem_addr}), 72'({1'b1, 1'b0, 32'h200}));
        pulse_aok();
        m_dok = 1'b1;
        @(negedge clk);
        m_dok = 1'b0;
        chk("ord_rd_data", 72'({bus.rd_valid, bus.rd_data}), 72'({1'b1, mk_word(32'h200, 0)}));
        check_writes("ord");
        for (int i = 0; i < 2; i++) begin
            wd[i] = $urandom;
            send(1'b1, 32'h4000 + 32'(4 * i), wd[i], 4'hF, 3, acc);
        end
        wd[2] = $urandom;
        m_aok = 1'b1;
        send(1'b1, 32'h4008, wd[2], 4'hF, 3, acc);
        m_aok = 1'b0;
        chk("sim_acc", 72'(acc), 72'd1);
        chk("sim_head", 72'(bus.mem_addr), 72'h4004);
        for (int i = 3; i < 5; i++) begin
            wd[i] = $urandom;
            send(1'b1, 32'h4000 + 32'(4 * i), wd[i], 4'hF, 0, acc);
            chk("sim_fill", 72'(acc), 72'd1);
        end
        wd[5] = $urandom;
        send(1'b1, 32'h4014, wd[5], 4'hF, 3, acc);
        chk("sim_full", 72'(acc), 72'd0);
        m_aok = 1'b1;
        wait_acc(10, acc);
        chk("sim_last_acc", 72'(acc), 72'd1);
        if (acc) exp_wq.push_back('{32'h4014, wd[5], 4'hF, 2'd2});
        wait_empty("sim_drain", 20);
        m_aok = 1'b0;
        check_writes("sim");
        send(1'b0, 32'h340, 32'h0, 4'h0, 3, acc);
        pulse_aok();
        rstn = 1'b0;
        #1;
        chk("mid_rst_out", 72'({bus.mem_req, bus.mem_wr, bus.mem_wstrb, bus.mem_size, bus.rd_valid}), 72'd0);
        chk("mid_rst_rdata", 72'(bus.rd_data), 72'd0);
        chk("mid_rst_flags", 72'({bus.req_ready, bus.wbuf_empty}), 72'({1'b1, 1'b1}));
        @(negedge clk);
        rstn = 1'b1;
        m_dok = 1'b1;
        @(negedge clk);
        m_dok = 1'b0;
        chk("mid_rst_nordv", 72'(bus.rd_valid), 72'd0);
        @(negedge clk);
        chk("mid_rst_nordv2", 72'({bus.rd_valid, bus.mem_req}), 72'd0);
        auto_mem = 1'b1;
        for (int n = 0; n < 60; n++) begin
            a = $urandom;
            if ($urandom_range(0, 2) != 0) begin
                d = $urandom;
                s = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                send(1'b1, a, d, s, 40, acc);
                chk("rnd_wacc", 72'(acc), 72'd1);
            end else begin
                send(1'b0, a, 32'h0, 4'h0, 60, acc);
                chk("rnd_racc", 72'(acc), 72'd1);
                chk("rnd_order", 72'(iss_q.size()), 72'(exp_wq.size()));
                ok = 1'b0;
                for (int k = 0; k < 40; k++) begin
                    @(negedge clk);
                    if (bus.rd_valid) begin
                        ok = 1'b1;
                        break;
                    end
                end
                chk("rnd_rdv", 72'(ok), 72'd1);
                if (ok) begin
                    chk("rnd_rdata", 72'(bus.rd_data), 72'(mk_word(a, int'(a[3:2]))));
                    @(negedge clk);
                    chk("rnd_pulse", 72'(bus.rd_valid), 72'd0);
                end
            end
        end
        wait_empty("rnd_drain", 100);
        check_writes("rnd");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/dcache_uncache_bridge.md
DCACHE_UNCACHE_BRIDGE -- requirements
Module: dcache_uncache_bridge

Interface
REQ-001 Parameter: OFFSET_W, default 2, log2 of words per memory line; line width is 32*(1<<OFFSET_W) bits.
REQ-002 Parameter: WBUF_DEPTH, default 4, posted-write buffer entries; must be a power of two, at least 2.
REQ-003 clk  input  1  clock; all state changes on its rising edge.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  1  pipeline request valid.
REQ-006 req_ready  output  1  request accepted this cycle when req_valid && req_ready.
REQ-007 req_type  input  1  0 = read, 1 = write.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  write data, byte lanes aligned to the word.
REQ-010 req_wstrb  input  4  write byte enables.
REQ-011 rd_data  output  32  read result word.
REQ-012 rd_valid  output  1  one-cycle pulse; rd_data is valid.
REQ-013 wbuf_empty  output  1  write buffer holds no entries and no write is in flight.
REQ-014 mem_addr  output  32  memory request address.
REQ-015 mem_wdata  output  32  memory write data.
REQ-016 mem_rline  input  32*(1<<OFFSET_W)  memory read line.
REQ-017 mem_req / mem_wr  output  1 each  request strobe; 1 = write.
REQ-018 mem_size  output  2  0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes.
REQ-019 mem_wstrb  output  4  memory byte enables.
REQ-020 mem_addrOK / mem_dataOK  input  1 each  address accepted / read data returned.

Function
REQ-021 FSM states: IDLE, WREQ, RREQ, RWAIT; there are no other reachable states, and any illegal encoding goes to IDLE.
REQ-022 Write acceptance:
- req_ready = 1 for a write when the buffer count < WBUF_DEPTH and the state is not RREQ or RWAIT.
- An accepted write is enqueued with addr, wdata and wstrb.
- A write with wstrb = 0000 is accepted and discarded; it is not enqueued.
REQ-023 Read acceptance:
- req_ready = 1 for a read only in IDLE with the buffer empty; this drains all prior writes first to preserve ordering.
- An accepted read latches req_addr and moves to RREQ.
REQ-024 Write issue: IDLE with buffer non-empty → WREQ.
- In WREQ: mem_req = 1, mem_wr = 1, and mem_addr, mem_wdata, mem_wstrb come from the buffer head.
REQ-025 In WREQ, on mem_addrOK the head is popped; the state stays in WREQ if entries remain, else goes to IDLE. Writes are posted: mem_dataOK is not awaited.
REQ-026 mem_size for a write, from the head wstrb:
- single bit set → 0;
- 0011 or 1100 → 1;
- any other non-zero pattern → 2.
REQ-027 In RREQ: mem_req = 1, mem_wr = 0, mem_wstrb = 0000, mem_size = 2, mem_addr = latched address. On mem_addrOK → RWAIT.
REQ-028 In RWAIT, on mem_dataOK:
- rd_data is registered as word addr[OFFSET_W+1:2] of mem_rline;
- rd_valid pulses in the next cycle;
- the state returns to IDLE.
- rd_data holds its value until the next read completes.
REQ-029 mem_req = 0 in IDLE and RWAIT. mem_dataOK outside RWAIT is ignored.
REQ-030 Enqueue and pop in the same cycle leave the count unchanged and keep both entries correct. Pointers wrap modulo WBUF_DEPTH.
REQ-031 mem_addr, mem_wdata and mem_wstrb are held stable while mem_req = 1 and mem_addrOK = 0.

Reset
REQ-032 Asserting rstn low, at any time, immediately:
- puts the FSM in IDLE and clears the buffer pointers and count;
- sets rd_valid = 0, rd_data = 0, mem_req = 0, mem_wr = 0, mem_wstrb = 0, mem_size = 0;
- sets req_ready = 1 and wbuf_empty = 1.
REQ-033 A memory transaction in flight at reset is abandoned; no rd_valid pulse follows.

Verification
REQ-034 Single read: read at 0x104, OFFSET_W = 2 → one RREQ cycle; after dataOK with word 1 of the line = 0xDEADBEEF, rd_data = 0xDEADBEEF and rd_valid pulses for one cycle.
REQ-035 Write burst: 5 back-to-back writes, WBUF_DEPTH = 4, mem_addrOK held low → 4 writes accepted and the 5th stalls. After addrOK is released, 5 mem writes are issued in order with correct addr/data/wstrb.
REQ-036 Size decode: wstrb 0100, 1100 and 0111 → mem_size 0, 1 and 2 respectively. A write with wstrb 0000 produces no mem_req.
REQ-037 Ordering: a write to 0x200 is followed by a read of 0x200 → the read's req_ready stays 0 until the write's addrOK; mem_req for the read rises only after that.
REQ-038 Simultaneous enqueue and pop: with the buffer at 2 entries, enqueue and addrOK in the same cycle → count stays 2 and the FIFO order is preserved.
REQ-039 Reset mid-read: rstn low during RWAIT → outputs take their reset values; a later mem_dataOK causes no rd_valid.
